// File: rtl/adc_step_averager.sv
// Per-frequency-step ADC averager: drops SETTLE samples after step_start, then
// averages 2^LOG2_N offset-binary samples into one signed result tagged with the step index.
module adc_step_averager #(
    parameter int LOG2_N = 4,
    parameter int SETTLE = 8,
    parameter int STEP_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       adc_val,
    input  logic              sample_en,
    input  logic              sweep_start,
    input  logic              step_start,
    output logic [13:0]       avg_out,
    output logic              avg_valid,
    output logic [STEP_W-1:0] avg_idx,
    output logic              busy,
    output logic              overrun
);
    localparam int ACC_W = 14 + LOG2_N;
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [LOG2_N-1:0] SAMPLE_LAST = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACCUM} state_t;

    state_t                   state, state_next;
    logic [15:0]              settle_cnt;
    logic [LOG2_N-1:0]        sample_cnt;
    logic signed [ACC_W-1:0]  acc, acc_sum;
    logic [13:0]              sample;
    logic [STEP_W-1:0]        step_cnt;
    logic                     complete, start, valid_set, overrun_set;
    state_t                   first_state;

    // Offset binary to two's complement is an MSB flip.
    assign sample      = {~adc_val[13], adc_val[12:0]};
    assign acc_sum     = acc + {{LOG2_N{sample[13]}}, sample};
    assign complete    = (state == ST_ACCUM) && sample_en && (sample_cnt == SAMPLE_LAST);
    assign first_state = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        valid_set   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (step_start) start = 1'b1;
            end
            ST_SETTLE: begin
                if (step_start) begin
                    start       = 1'b1;
                    overrun_set = 1'b1;
                end else if (sample_en && settle_cnt == SETTLE_LAST) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (complete) begin
                    valid_set  = 1'b1;
                    state_next = ST_IDLE;
                    start      = step_start;
                end else if (step_start) begin
                    start       = 1'b1;
                    overrun_set = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (start) state_next = first_state;
        // Sweep restart silently discards whatever step was running.
        if (sweep_start) begin
            valid_set   = 1'b0;
            overrun_set = 1'b0;
            start       = step_start;
            state_next  = step_start ? first_state : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            acc        <= '0;
        end else if (start) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            acc        <= '0;
        end else if (sample_en) begin
            if (state == ST_SETTLE) settle_cnt <= settle_cnt + 16'd1;
            if (state == ST_ACCUM) begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_out   <= '0;
            avg_idx   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
            step_cnt  <= '0;
        end else begin
            avg_valid <= valid_set;
            overrun   <= overrun_set;
            if (valid_set) begin
                avg_out <= acc_sum[ACC_W-1:LOG2_N];
                avg_idx <= step_cnt;
            end
            if (sweep_start)    step_cnt <= '0;
            else if (valid_set) step_cnt <= step_cnt + STEP_W'(1);
        end
    end
endmodule

// File: tb/tb_adc_step_averager.sv
// Directed bench for adc_step_averager (LOG2_N=2, SETTLE=2, STEP_W=2) with a
// queue scoreboard checked by an independent output monitor.
module tb_adc_step_averager;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] adc_val = 14'h2000;
    logic        sample_en = 1'b0;
    logic        sweep_start = 1'b0;
    logic        step_start = 1'b0;
    logic [13:0] avg_out;
    logic        avg_valid;
    logic [1:0]  avg_idx;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int fails = 0;
    int busy_cycles = 0;
    int overrun_cnt = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];   // {avg_out, avg_idx}

    adc_step_averager #(.LOG2_N(2), .SETTLE(2), .STEP_W(2)) dut (
        .clk(clk), .rst(rst), .adc_val(adc_val), .sample_en(sample_en),
        .sweep_start(sweep_start), .step_start(step_start), .avg_out(avg_out),
        .avg_valid(avg_valid), .avg_idx(avg_idx), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every avg_valid strobe.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        if (busy) busy_cycles++;
        if (overrun) overrun_cnt++;
        if (avg_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_avg_valid", 32'(avg_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("avg_out", 32'(avg_out), 32'(e[15:2]));
                check("avg_idx", 32'(avg_idx), 32'(e[1:0]));
            end
        end
    end

    task automatic drive(input logic st, input logic sw, input logic en, input logic [13:0] v);
        @(negedge clk);
        step_start  = st;
        sweep_start = sw;
        sample_en   = en;
        adc_val     = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 14'h3FFF);
    endtask

    task automatic sample(input logic [13:0] v);
        drive(1'b0, 1'b0, 1'b1, v);
    endtask

    // step_start edge, two settle samples, three accumulate samples; caller issues the 4th.
    task automatic step_to_last(input logic [13:0] sv, input logic [13:0] a0,
                                input logic [13:0] a1, input logic [13:0] a2);
        drive(1'b1, 1'b0, 1'b1, 14'h3FFF);
        sample(sv);
        sample(sv);
        sample(a0);
        sample(a1);
        sample(a2);
    endtask

    task automatic full_step(input logic [13:0] sv, input logic [13:0] a0, input logic [13:0] a1,
                             input logic [13:0] a2, input logic [13:0] a3,
                             input logic [13:0] exp_avg, input logic [1:0] exp_idx);
        exp_q.push_back({exp_avg, exp_idx});
        step_to_last(sv, a0, a1, a2);
        sample(a3);
        @(posedge clk);
        #1;
        check("valid_after_last", 32'(avg_valid), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_avg_out", 32'(avg_out), 32'd0);
        check("rst_avg_valid", 32'(avg_valid), 32'd0);
        check("rst_avg_idx", 32'(avg_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        idle(2);

        // Zero input; busy must be high for exactly 6 cycles
        busy_cycles = 0;
        full_step(14'h2000, 14'h2000, 14'h2000, 14'h2000, 14'h2000, 14'h0000, 2'd0);
        check("zero_busy_cycles", 32'(busy_cycles), 32'd6);

        // Full scale positive then negative, indices restart after sweep
        drive(1'b0, 1'b1, 1'b0, 14'h2000);
        idle(1);
        full_step(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h1FFF, 2'd0);
        full_step(14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h2000, 2'd1);

        // Floor of -8191.5 is -8192; settle samples at full scale must be excluded
        full_step(14'h3FFF, 14'h0000, 14'h0001, 14'h0000, 14'h0001, 14'h2000, 2'd2);

        // Throttled: one strobe every 10th cycle; gaps carry 3FFF which must be ignored.
        // Accumulated s = 4, 8, 0, 0 -> 12 >>> 2 = 3
        exp_q.push_back({14'h0003, 2'd3});
        drive(1'b1, 1'b0, 1'b0, 14'h3FFF);
        begin
            logic [13:0] tv [6];
            tv[0] = 14'h0000; tv[1] = 14'h0000; tv[2] = 14'h2004;
            tv[3] = 14'h2008; tv[4] = 14'h2000; tv[5] = 14'h2000;
            valid_cnt = 0;
            for (int s = 0; s < 6; s++) begin
                idle(9);
                if (s == 5) check("throttle_busy_before_last", 32'(busy), 32'd1);
                sample(tv[s]);
            end
        end
        idle(3);
        check("throttle_valid_count", 32'(valid_cnt), 32'd1);

        // 5th step since sweep wraps the 2-bit index; s=-1 each -> -1 (3FFF)
        full_step(14'h2000, 14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h3FFF, 2'd0);

        // Overrun during ACCUM, then step_start on the completing edge
        drive(1'b0, 1'b1, 1'b0, 14'h2000);
        idle(1);
        drive(1'b1, 1'b0, 1'b1, 14'h3FFF);
        sample(14'h3FFF);
        sample(14'h3FFF);
        sample(14'h3FFF);
        sample(14'h3FFF);
        drive(1'b1, 1'b0, 1'b1, 14'h3FFF);
        @(posedge clk);
        #1;
        check("overrun_pulse", 32'(overrun), 32'd1);
        check("overrun_busy", 32'(busy), 32'd1);
        exp_q.push_back({14'h0010, 2'd0});
        sample(14'h3FFF);
        sample(14'h3FFF);
        sample(14'h2010);
        sample(14'h2010);
        sample(14'h2010);
        exp_q.push_back({14'h0020, 2'd1});
        drive(1'b1, 1'b0, 1'b1, 14'h2010);
        @(posedge clk);
        #1;
        check("back2back_valid", 32'(avg_valid), 32'd1);
        check("back2back_busy", 32'(busy), 32'd1);
        check("back2back_overrun", 32'(overrun), 32'd0);
        sample(14'h0000);
        sample(14'h0000);
        sample(14'h2020);
        sample(14'h2020);
        sample(14'h2020);
        sample(14'h2020);
        idle(3);
        check("overrun_count", 32'(overrun_cnt), 32'd1);

        // Sweep mid-step aborts silently; coincident step_start begins at index 0
        step_to_last(14'h2000, 14'h3FFF, 14'h3FFF, 14'h3FFF);
        drive(1'b0, 1'b1, 1'b1, 14'h3FFF);
        @(posedge clk);
        #1;
        check("sweep_abort_busy", 32'(busy), 32'd0);
        check("sweep_abort_valid", 32'(avg_valid), 32'd0);
        idle(1);
        exp_q.push_back({14'h0040, 2'd0});
        drive(1'b1, 1'b1, 1'b1, 14'h3FFF);
        sample(14'h3FFF);
        sample(14'h3FFF);
        repeat (4) sample(14'h2040);
        idle(3);

        // Async reset mid-ACCUM clears outputs immediately; nothing completes afterwards
        step_to_last(14'h2000, 14'h3FFF, 14'h3FFF, 14'h3FFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_avg_out", 32'(avg_out), 32'd0);
        check("midrst_avg_idx", 32'(avg_idx), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(avg_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) sample(14'h3FFF);
        idle(2);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid_count", 32'(valid_cnt), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final_overrun_count", 32'(overrun_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
